// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    function automatic int depth_f(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks every register index once, writing zero.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              clr_start_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_o      = 1'b0;
        clr_we_o    = 1'b0;
        clr_start_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d     = CLEAR;
                    idx_d       = '0;
                    clr_start_o = 1'b1;
                end
            end
            CLEAR: begin
                busy_o   = 1'b1;
                clr_we_o = 1'b1;
                idx_d    = idx_q + 1'b1;
                if (idx_q == '1) state_d = IDLE;
            end
        endcase
    end

    assign clr_addr_o = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with bypass, pending scoreboard
// and a sequential clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_WR-1:0]              we_i,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wa_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wd_i,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  ra_i,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_o,
    output logic [NUM_RD-1:0]              pend_o,
    input  logic                           pset_i,
    input  logic [ADDR_W-1:0]              pset_wa_i,
    input  logic                           clr_req_i,
    output logic                           busy_o
);

    localparam int DEPTH = depth_f(ADDR_W);

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              clr_we, clr_start;
    logic [ADDR_W-1:0] clr_addr;

    regfile_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_req_i  (clr_req_i),
        .busy_o     (busy_o),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .clr_start_o(clr_start)
    );

    // Storage has no reset; the clear engine zeroes it after every reset.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            rf_q[clr_addr] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (we_i[w] && !(ZERO_REG && wa_i[w] == '0))
                    rf_q[wa_i[w]] <= wd_i[w];
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (clr_start || busy_o) begin
            pend_d = '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (we_i[w]) pend_d[wa_i[w]] = 1'b0;
            end
            // A new issue outranks a retiring producer of the same register.
            if (pset_i && !(ZERO_REG && pset_wa_i == '0))
                pend_d[pset_wa_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) pend_q <= '0;
        else         pend_q <= pend_d;
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_o[k]   = '0;
            pend_o[k] = 1'b0;
            if (!busy_o && !(ZERO_REG && ra_i[k] == '0)) begin
                rd_o[k]   = rf_q[ra_i[k]];
                pend_o[k] = pend_q[ra_i[k]];
                if (BYPASS) begin
                    for (int w = 0; w < NUM_WR; w++) begin
                        if (we_i[w] && wa_i[w] == ra_i[k]) begin
                            rd_o[k]   = wd_i[w];
                            pend_o[k] = 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypass/2-write instance plus a no-bypass instance.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       a_we;
    logic [1:0][4:0]  a_wa;
    logic [1:0][31:0] a_wd;
    logic [1:0][4:0]  a_ra;
    logic [1:0][31:0] a_rd;
    logic [1:0]       a_pend;
    logic             a_pset;
    logic [4:0]       a_pwa;
    logic             a_clr;
    logic             a_busy;

    logic [0:0]       b_we;
    logic [0:0][4:0]  b_wa;
    logic [0:0][31:0] b_wd;
    logic [0:0][4:0]  b_ra;
    logic [0:0][31:0] b_rd;
    logic [0:0]       b_pend;
    logic             b_pset;
    logic [4:0]       b_pwa;
    logic             b_clr;
    logic             b_busy;

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
        .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut_a (
        .clk_i(clk), .reset_i(rst),
        .we_i(a_we), .wa_i(a_wa), .wd_i(a_wd),
        .ra_i(a_ra), .rd_o(a_rd), .pend_o(a_pend),
        .pset_i(a_pset), .pset_wa_i(a_pwa),
        .clr_req_i(a_clr), .busy_o(a_busy)
    );

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(1), .NUM_WR(1),
        .BYPASS(1'b0), .ZERO_REG(1'b1)
    ) dut_b (
        .clk_i(clk), .reset_i(rst),
        .we_i(b_we), .wa_i(b_wa), .wd_i(b_wd),
        .ra_i(b_ra), .rd_o(b_rd), .pend_o(b_pend),
        .pset_i(b_pset), .pset_wa_i(b_pwa),
        .clr_req_i(b_clr), .busy_o(b_busy)
    );

    typedef struct {
        int          we;
        int          wa0;
        int          wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        int          ra0;
        int          ra1;
        int          pset;
        int          pwa;
        logic [31:0] e0;
        logic [31:0] e1;
        int          ep0;
        int          ep1;
    } vec_t;

    typedef struct {
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        p0;
        logic        p1;
    } exp_t;

    vec_t vt[12];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        exp_t e;

        vt[0]  = '{1, 5, 0, 32'hDEADBEEF, 0, 5, 5, 0, 0,
                   32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        vt[1]  = '{0, 0, 0, 0, 0, 5, 6, 0, 0, 32'hDEADBEEF, 0, 0, 0};
        vt[2]  = '{3, 7, 7, 32'h11, 32'h22, 7, 5, 0, 0,
                   32'h22, 32'hDEADBEEF, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 0, 7, 0, 0, 0, 32'h22, 0, 0, 0};
        vt[4]  = '{1, 0, 0, 32'h1234, 0, 0, 7, 1, 0, 0, 32'h22, 0, 0};
        vt[5]  = '{0, 0, 0, 0, 0, 0, 9, 1, 9, 0, 0, 0, 0};
        vt[6]  = '{0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 1, 0};
        vt[7]  = '{2, 0, 9, 0, 32'h99, 9, 9, 0, 0, 32'h99, 32'h99, 0, 0};
        vt[8]  = '{1, 9, 0, 32'hAA, 0, 9, 9, 1, 9, 32'hAA, 32'hAA, 0, 0};
        vt[9]  = '{0, 0, 0, 0, 0, 9, 5, 0, 0, 32'hAA, 32'hDEADBEEF, 1, 0};
        vt[10] = '{1, 3, 0, 32'hA5, 0, 3, 12, 1, 12, 32'hA5, 0, 0, 0};
        vt[11] = '{0, 0, 0, 0, 0, 3, 12, 0, 0, 32'hA5, 0, 0, 1};

        rst = 1'b1;
        a_we = '0; a_wa = '0; a_wd = '0; a_ra = '0;
        a_pset = 1'b0; a_pwa = '0; a_clr = 1'b0;
        b_we = '0; b_wa = '0; b_wd = '0; b_ra = '0;
        b_pset = 1'b0; b_pwa = '0; b_clr = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy_a", 32'(a_busy), 32'd1);
        chk("rst_busy_b", 32'(b_busy), 32'd1);
        chk("rst_rd0", a_rd[0], 32'h0);
        chk("rst_pend0", 32'(a_pend[0]), 32'd0);

        rst = 1'b0;
        n = 0;
        while (a_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("init_clear_cycles", n, 32'd32);
        chk("init_busy_b", 32'(b_busy), 32'd0);

        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            a_ra[0] = 5'(i);
            a_ra[1] = 5'(31 - i);
            #1;
            chk($sformatf("zero_r%0d", i), a_rd[0], 32'h0);
            chk($sformatf("zero_r%0d_b", 31 - i), a_rd[1], 32'h0);
        end

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a_we    = 2'(vt[i].we);
            a_wa[0] = 5'(vt[i].wa0);
            a_wa[1] = 5'(vt[i].wa1);
            a_wd[0] = vt[i].wd0;
            a_wd[1] = vt[i].wd1;
            a_ra[0] = 5'(vt[i].ra0);
            a_ra[1] = 5'(vt[i].ra1);
            a_pset  = vt[i].pset[0];
            a_pwa   = 5'(vt[i].pwa);
            sb.push_back('{vt[i].e0, vt[i].e1, vt[i].ep0[0], vt[i].ep1[0]});
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_rd0", i), a_rd[0], e.rd0);
            chk($sformatf("v%0d_rd1", i), a_rd[1], e.rd1);
            chk($sformatf("v%0d_p0", i), 32'(a_pend[0]), 32'(e.p0));
            chk($sformatf("v%0d_p1", i), 32'(a_pend[1]), 32'(e.p1));
        end
        @(negedge clk);
        a_we = '0; a_pset = 1'b0;

        // No-bypass instance: same-cycle read sees old storage
        b_we = 1'b1; b_wa[0] = 5'd5; b_wd[0] = 32'hDEADBEEF; b_ra[0] = 5'd5;
        b_pset = 1'b1; b_pwa = 5'd4;
        #1;
        chk("nb_same_cycle", b_rd[0], 32'h0);
        @(negedge clk);
        b_we = 1'b0; b_pset = 1'b0;
        #1;
        chk("nb_next_cycle", b_rd[0], 32'hDEADBEEF);
        b_ra[0] = 5'd4;
        #1;
        chk("nb_pend_set", 32'(b_pend[0]), 32'd1);
        @(negedge clk);
        b_we = 1'b1; b_wa[0] = 5'd4; b_wd[0] = 32'h44;
        #1;
        chk("nb_wb_rd_old", b_rd[0], 32'h0);
        chk("nb_wb_pend_unmasked", 32'(b_pend[0]), 32'd1);
        @(negedge clk);
        b_we = 1'b0;
        #1;
        chk("nb_wb_rd_new", b_rd[0], 32'h44);
        chk("nb_wb_pend_clr", 32'(b_pend[0]), 32'd0);

        // Clear request; writes and psets during the clear are dropped
        @(negedge clk);
        b_clr = 1'b1;
        b_we = 1'b1; b_wa[0] = 5'd6; b_wd[0] = 32'h77;
        b_pset = 1'b1; b_pwa = 5'd6;
        @(posedge clk); #1;
        n = 1;
        b_clr = 1'b0;
        chk("clr_busy_rise", 32'(b_busy), 32'd1);
        while (b_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("clr_req_to_idle", n, 32'd33);
        b_we = 1'b0; b_pset = 1'b0; b_ra[0] = 5'd6;
        #1;
        chk("clr_r6_rd", b_rd[0], 32'h0);
        chk("clr_r6_pend", 32'(b_pend[0]), 32'd0);
        b_ra[0] = 5'd5;
        #1;
        chk("clr_r5_rd", b_rd[0], 32'h0);

        // Clear on the bypass instance, interrupted by reset at index 10
        @(negedge clk);
        a_clr = 1'b1; a_ra[0] = 5'd3; a_ra[1] = 5'd9;
        #1;
        chk("pre_clr_r3", a_rd[0], 32'hA5);
        chk("pre_clr_p9", 32'(a_pend[1]), 32'd1);
        @(posedge clk); #1;
        a_clr = 1'b0;
        chk("clr_a_busy", 32'(a_busy), 32'd1);
        chk("clr_a_rd_masked", a_rd[0], 32'h0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (a_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("restart_clear_cycles", n, 32'd32);
        chk("post_clr_r3", a_rd[0], 32'h0);
        chk("post_clr_r9", a_rd[1], 32'h0);
        chk("post_clr_p9", 32'(a_pend[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined MIPS datapath, successor to the fixed 2-read/1-write 32×32 file. Adds configurable width/depth/port count, same-cycle write-to-read bypass, a per-register pending scoreboard for hazard detection, and a sequential clear engine that zeroes storage after reset or on request. Sits in the decode stage; writeback ports drive the write side.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W
- NUM_RD, 2, read ports
- NUM_WR, 1, write ports; on same-address collision the highest index wins
- BYPASS, 1, 1 = write data forwarded to matching reads in the same cycle
- ZERO_REG, 1, 1 = register 0 reads 0, writes and pending-sets to it are discarded

- clk_i  in  1  clock, rising edge
- reset_i  in  1  reset; asynchronous and active-high
- we_i  in  NUM_WR  write enables
- wa_i  in  NUM_WR×ADDR_W  write addresses
- wd_i  in  NUM_WR×DATA_W  write data
- ra_i  in  NUM_RD×ADDR_W  read addresses
- rd_o  out  NUM_RD×DATA_W  read data (combinational)
- pend_o  out  NUM_RD  read target has an outstanding producer
- pset_i  in  1  mark pset_wa_i pending (instruction issued)
- pset_wa_i  in  ADDR_W  destination being marked
- clr_req_i  in  1  request full clear
- busy_o  out  1  clear engine active

## Operation
- FSM states: IDLE, CLEAR. Reset asserted: state=CLEAR, index=0, all pending bits=0. Reset release: CLEAR continues from index 0.
- CLEAR: each edge writes 0 to rf[index], index++; after index DEPTH-1 → IDLE. Duration exactly DEPTH cycles. busy_o=1 throughout; we_i, pset_i, clr_req_i ignored; rd_o=0, pend_o=0.
- IDLE: clr_req_i=1 → CLEAR next edge (index=0, pending bits cleared at that edge).
- Write: we_i[w] → rf[wa_i[w]] <= wd_i[w] on edge; also clears pending[wa_i[w]].
- Pending: pset_i → pending[pset_wa_i] <= 1. Set and writeback clear to the same address in one cycle: set wins.
- Read k: if ZERO_REG and ra=0 → 0, pend_o=0. Else if BYPASS and any we_i[w] with wa_i[w]=ra (highest w) → wd_i[w], pend_o=0. Else rf[ra], pend_o=pending[ra].
- BYPASS=0: reads return pre-edge storage; pend_o unmasked.

## Timing
- Reset values: rd_o=0, pend_o=0, busy_o=1 (until DEPTH cycles after release).
- Read latency 0 (combinational from ra_i, plus we_i/wa_i/wd_i when BYPASS=1).
- Write visible from storage the cycle after the edge; via bypass same cycle.
- pset visible on pend_o the cycle after the edge.
- clr_req_i in IDLE: busy_o rises next cycle, falls DEPTH+1 cycles after request.
- Reset mid-clear: restarts at index 0.

## Structure
- Package regfile_pkg: state enum (IDLE, CLEAR), function for DEPTH from ADDR_W.
- Sub-module regfile_clear_fsm: state, index counter, busy_o, clear-write strobe/address; top muxes clear writes over port writes.
- Storage, pending vector, bypass/priority logic in top.

## Test plan
- Reset release, DEPTH=32 → busy_o=1 for 32 cycles, then 0; every ra reads 0x00000000.
- Write r5=0xDEADBEEF with ra0=5 same cycle → rd_o[0]=0xDEADBEEF same cycle (BYPASS=1); BYPASS=0 → old value, new value next cycle.
- NUM_WR=2, both write r7 (0x11, 0x22) → r7=0x22.
- Write r0=0x1234, pset r0 → rd_o=0, pend_o=0 (ZERO_REG=1).
- pset r9, next cycle ra=9 → pend_o=1; writeback r9 → pend_o=0 same cycle via bypass; pset and writeback r9 together → pending stays 1.
- clr_req_i after loading r3=0xA5, reset pulsed at clear index 10 → restart, busy_o 32 more cycles, r3 reads 0.
